// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared sizing helpers and default parameters for the single-clock FIFO controller
// and its dual-port RAM.
package sync_fifo_ctrl_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH_LOG = 8;

    // Number of RAM entries (FIFO_DEPTH) for a given address width.
    function automatic int fifo_depth(input int depth_log);
        return 1 << depth_log;
    endfunction

    // Pointer width (PTR_W): RAM address plus one wrap bit that separates full from empty.
    function automatic int ptr_width(input int depth_log);
        return depth_log + 1;
    endfunction

endpackage

// File: rtl/pkg_dual_ram.sv
// Simple dual-port RAM: synchronous write port and a registered read port with one
// cycle of latency. Contents are not reset.
module pkg_dual_ram
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH_LOG = DEF_DEPTH_LOG
) (
    input  logic                 clk,
    input  logic                 ram_write_req,
    input  logic [DEPTH_LOG-1:0] ram_write_addr,
    input  logic [WIDTH-1:0]     ram_write_data,
    input  logic                 ram_read_req,
    input  logic [DEPTH_LOG-1:0] ram_read_addr,
    output logic [WIDTH-1:0]     ram_read_data
);

    localparam int FIFO_DEPTH = fifo_depth(DEPTH_LOG);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (ram_write_req) begin
            mem_q[ram_write_addr] <= ram_write_data;
        end
    end

    // Read register only loads on a request, so data holds between reads.
    always_ff @(posedge clk) begin
        if (ram_read_req) begin
            rdata_q <= mem_q[ram_read_addr];
        end
    end

    assign ram_read_data = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: owns the wrap-bit pointers, the occupancy flags and the
// error pulses, and drives the dual-port RAM that holds the data.
//
// Handshake: a write is taken on any rising edge where fifo_write_req=1 and fifo_full=0;
// a read is taken on any rising edge where fifo_read_req=1 and fifo_empty=0, and its data
// is presented with fifo_read_valid=1 for exactly the following cycle. A request against a
// blocking flag is dropped and reported by a one-cycle overflow/underflow pulse.
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH_LOG = DEF_DEPTH_LOG
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_write_req,
    input  logic [WIDTH-1:0]     fifo_write_data,
    output logic                 fifo_full,
    input  logic                 fifo_read_req,
    output logic [WIDTH-1:0]     fifo_read_data,
    output logic                 fifo_read_valid,
    output logic                 fifo_empty,
    output logic [DEPTH_LOG:0]   fifo_count,
    output logic                 fifo_overflow,
    output logic                 fifo_underflow
);

    localparam int              PTR_W   = ptr_width(DEPTH_LOG);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             read_valid_q, read_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             write_accept;
    logic             read_accept;
    logic [WIDTH-1:0] ram_read_data;

    // Flags come from the registered pointers only; equal wrap bits mean empty, differing mean full.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[DEPTH_LOG-1:0] == rd_ptr_q[DEPTH_LOG-1:0]);
        fifo_count = wr_ptr_q - rd_ptr_q;
    end

    always_comb begin
        write_accept = fifo_write_req & ~fifo_full;
        read_accept  = fifo_read_req & ~fifo_empty;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        read_valid_d = read_accept;
        overflow_d   = fifo_write_req & fifo_full;
        underflow_d  = fifo_read_req & fifo_empty;
        if (write_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (read_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            read_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            read_valid_q <= read_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign fifo_read_valid = read_valid_q;
    assign fifo_overflow   = overflow_q;
    assign fifo_underflow  = underflow_q;
    assign fifo_read_data  = ram_read_data;

    pkg_dual_ram #(
        .WIDTH    (WIDTH),
        .DEPTH_LOG(DEPTH_LOG)
    ) u_ram (
        .clk           (clk),
        .ram_write_req (write_accept),
        .ram_write_addr(wr_ptr_q[DEPTH_LOG-1:0]),
        .ram_write_data(fifo_write_data),
        .ram_read_req  (read_accept),
        .ram_read_addr (rd_ptr_q[DEPTH_LOG-1:0]),
        .ram_read_data (ram_read_data)
    );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (WIDTH=8, DEPTH_LOG=2) with a read-data scoreboard.
module tb_sync_fifo_ctrl;

  localparam int WIDTH     = 8;
  localparam int DEPTH_LOG = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 fifo_write_req;
  logic [WIDTH-1:0]     fifo_write_data;
  logic                 fifo_full;
  logic                 fifo_read_req;
  logic [WIDTH-1:0]     fifo_read_data;
  logic                 fifo_read_valid;
  logic                 fifo_empty;
  logic [DEPTH_LOG:0]   fifo_count;
  logic                 fifo_overflow;
  logic                 fifo_underflow;

  logic [WIDTH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  sync_fifo_ctrl #(
    .WIDTH    (WIDTH),
    .DEPTH_LOG(DEPTH_LOG)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_write_req (fifo_write_req),
    .fifo_write_data(fifo_write_data),
    .fifo_full      (fifo_full),
    .fifo_read_req  (fifo_read_req),
    .fifo_read_data (fifo_read_data),
    .fifo_read_valid(fifo_read_valid),
    .fifo_empty     (fifo_empty),
    .fifo_count     (fifo_count),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string name, input logic e, input logic f,
                             input int c, input logic o, input logic u);
    chk({name, "_empty"}, 32'(fifo_empty), 32'(e));
    chk({name, "_full"}, 32'(fifo_full), 32'(f));
    chk({name, "_count"}, 32'(fifo_count), 32'(c));
    chk({name, "_overflow"}, 32'(fifo_overflow), 32'(o));
    chk({name, "_underflow"}, 32'(fifo_underflow), 32'(u));
  endtask

  // driver: one request cycle; a read expected to be accepted queues its data
  task automatic step(input logic wr, input logic [WIDTH-1:0] wd, input logic rd,
                      input logic exp_pop, input logic [WIDTH-1:0] ed);
    @(negedge clk);
    fifo_write_req  = wr;
    fifo_write_data = wd;
    fifo_read_req   = rd;
    if (exp_pop) exp_q.push_back(ed);
    @(posedge clk);
    #1;
    fifo_write_req = 1'b0;
    fifo_read_req  = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  // monitor: valid must appear exactly one edge after the read that queued its data
  initial begin
    logic [WIDTH-1:0] d;
    forever begin
      @(posedge clk);
      #1;
      if (fifo_read_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(fifo_read_valid), 32'd0);
        end else begin
          d = exp_q.pop_front();
          chk("read_data", 32'(fifo_read_data), 32'(d));
        end
      end else if (exp_q.size() != 0) begin
        d = exp_q.pop_front();
        chk("missing_valid", 32'(fifo_read_valid), 32'd1);
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    fifo_write_req  = 1'b0;
    fifo_write_data = '0;
    fifo_read_req   = 1'b0;
    #12;
    check_flags("reset", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("reset_valid", 32'(fifo_read_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();
    check_flags("idle", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // read on empty
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check_flags("underflow_pulse", 1'b1, 1'b0, 0, 1'b0, 1'b1);
    idle();
    check_flags("underflow_once", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // fill
    step(1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
    check_flags("fill1", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
    check_flags("fill2", 1'b0, 1'b0, 2, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    check_flags("fill3", 1'b0, 1'b0, 3, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0, 8'h00);
    check_flags("fill4", 1'b0, 1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
    check_flags("overflow_pulse", 1'b0, 1'b1, 4, 1'b1, 1'b0);
    idle();
    check_flags("overflow_once", 1'b0, 1'b1, 4, 1'b0, 1'b0);

    // drain
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h11);
    check_flags("drain1", 1'b0, 1'b0, 3, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h22);
    check_flags("drain2", 1'b0, 1'b0, 2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h33);
    check_flags("drain3", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h44);
    check_flags("drain4", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // wrap-around: pointers start at 4 and pass through 0
    step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    check_flags("wrap_first", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b1, 8'(i - 1));
      check_flags("wrap_pair", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h09);
    check_flags("wrap_last", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // simultaneous read+write at count=2, full, and empty
    step(1'b1, 8'hA0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'hA2, 1'b1, 1'b1, 8'hA0);
    check_flags("rw_count2_a", 1'b0, 1'b0, 2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b1, 1'b1, 8'hA1);
    check_flags("rw_count2_b", 1'b0, 1'b0, 2, 1'b0, 1'b0);
    step(1'b1, 8'hA4, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    check_flags("rw_full", 1'b0, 1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 8'hA6, 1'b1, 1'b1, 8'hA2);
    check_flags("rw_when_full", 1'b0, 1'b0, 3, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hA3);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hA4);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5);
    check_flags("rw_drained", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 8'hB0, 1'b1, 1'b0, 8'h00);
    check_flags("rw_when_empty", 1'b0, 1'b0, 1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hB0);
    check_flags("rw_empty_read", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // reset mid-stream
    step(1'b1, 8'hC0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'hC1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'hC2, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hC0);
    check_flags("pre_reset", 1'b0, 1'b0, 3, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(fifo_read_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", 32'(fifo_read_valid), 32'd0);
    check_flags("mid_reset", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    check_flags("post_reset_wr", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5);
    check_flags("post_reset_rd", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    repeat (3) idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock FIFO that drives the dual-port RAM storage (`pkg_dual_ram`). It owns all pointer and flag logic and exposes a request/flag interface to producer and consumer. It generates RAM write strobes and addresses, and RAM read addresses. It returns RAM read data to the consumer with a valid strobe that follows the RAM's one-cycle read latency.

## Interface
- `WIDTH`, 8, data word width in bits.
- `DEPTH_LOG`, 8, log2 of FIFO depth; depth = 2^DEPTH_LOG entries.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `fifo_write_req` input 1: producer write request.
- `fifo_write_data` input WIDTH: write data, sampled with `fifo_write_req`.
- `fifo_full` output 1: FIFO holds 2^DEPTH_LOG entries.
- `fifo_read_req` input 1: consumer read request.
- `fifo_read_data` output WIDTH: read data, meaningful only when `fifo_read_valid`=1.
- `fifo_read_valid` output 1: one-cycle strobe, data for an accepted read.
- `fifo_empty` output 1: FIFO holds 0 entries.
- `fifo_count` output DEPTH_LOG+1: current occupancy, 0 to 2^DEPTH_LOG.
- `fifo_overflow` output 1: one-cycle pulse, write request rejected because full.
- `fifo_underflow` output 1: one-cycle pulse, read request rejected because empty.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are each DEPTH_LOG+1 bits.
  - The low DEPTH_LOG bits are the RAM address.
  - The MSB is the wrap bit.
  - Both pointers increment modulo 2^(DEPTH_LOG+1).
- Flags:
  - `fifo_empty` = (`wr_ptr` == `rd_ptr`).
  - `fifo_full` = (MSBs differ) and (low bits equal).
  - `fifo_count` = `wr_ptr` − `rd_ptr`, modulo 2^(DEPTH_LOG+1).
  - All three are derived from registered pointers only.
- Acceptance is evaluated against the flags as they stand in the current cycle:
  - write_accept = `fifo_write_req` & ~`fifo_full`.
  - read_accept = `fifo_read_req` & ~`fifo_empty`.
- On write_accept:
  - RAM `ram_write_req`=1, `ram_write_addr`=`wr_ptr`[DEPTH_LOG-1:0], `ram_write_data`=`fifo_write_data`.
  - `wr_ptr` increments.
- On read_accept:
  - `ram_read_addr`=`rd_ptr`[DEPTH_LOG-1:0]; `rd_ptr` increments.
  - `fifo_read_valid` is registered high for the next cycle.
  - `fifo_read_data` = RAM `ram_read_data`, passed straight through.
- Simultaneous read and write:
  - Both are accepted when neither flag blocks; count is unchanged.
  - When full: only the read is accepted and `fifo_overflow` pulses.
  - When empty: only the write is accepted, `fifo_underflow` pulses, and the written word is readable from the next cycle.
- Rejected requests change no state other than the error pulse.
- Same-address read/write in one cycle cannot occur, because empty blocks it. No bypass path is required.

## Timing
- Reset values, applied asynchronously:
  - `wr_ptr`=`rd_ptr`=0.
  - `fifo_empty`=1, `fifo_full`=0, `fifo_count`=0.
  - `fifo_read_valid`=0, `fifo_overflow`=0, `fifo_underflow`=0.
- RAM contents are not reset. `fifo_read_data` is don't-care while `fifo_read_valid`=0.
- Reset asserted mid-operation:
  - All pointers and flags return to their reset values immediately.
  - Any pending `fifo_read_valid` is cancelled.
  - Data in the RAM is logically discarded.
- Write-to-flag latency: 1 cycle. After an accepted write at edge N, `fifo_empty` falls after edge N.
- Read latency: 1 cycle. A request accepted at edge N gives `fifo_read_valid`=1 and data in the cycle after edge N.
- Full throughput: one write and one read per cycle is sustained indefinitely.
- `fifo_overflow` and `fifo_underflow` are registered and assert in the cycle after the rejected request.

## Structure
- Shared package/header constants:
  - `FIFO_DEPTH` = 1<<DEPTH_LOG.
  - `PTR_W` = DEPTH_LOG+1.
- One sub-module, `pkg_dual_ram`:
  - Instantiated with the same WIDTH/DEPTH_LOG.
  - Connected to clk and to the write/read address, data and strobe nets described above.
- Target size: ~150–250 lines of RTL.

## Test plan
All scenarios use DEPTH_LOG=2, WIDTH=8.
- Reset, then idle:
  - `fifo_empty`=1, `fifo_full`=0, `fifo_count`=0.
  - `fifo_read_valid` never asserts.
  - `fifo_read_req` for 1 cycle pulses `fifo_underflow` once.
- Fill and drain:
  - Write 0x11, 0x22, 0x33, 0x44 → `fifo_full`=1, `fifo_count`=4.
  - A fifth write 0x55 pulses `fifo_overflow` and is not stored.
  - Four reads return 0x11..0x44 in order, each one cycle after its request; then `fifo_empty`=1.
- Wrap-around:
  - Run 10 write/read pairs with data 0x00..0x09, keeping occupancy ≤2.
  - Output order must match input and `fifo_count` must stay correct across pointer wrap.
- Simultaneous read+write:
  - At count=2, concurrent requests leave count at 2 with data in order.
  - When full, a concurrent request reads the oldest entry, rejects the write (overflow pulse) and gives count=3.
  - When empty, a concurrent request accepts the write only (underflow pulse) and gives count=1.
- Reset mid-stream:
  - Assert `rst_n`=0 with count=3 and a read accepted the previous edge.
  - `fifo_read_valid` drops immediately, `fifo_count`=0 and `fifo_empty`=1.
  - A subsequent write of 0xA5 then read returns 0xA5.
